// File: rtl/flappy_game.sv
// Frame-rate game engine: bird physics, two scrolling pipe pairs, collision and scoring.
// Optional build macro FLAPPY_NOCOLLIDE_EN removes pipe collision; only the ground ends a game.
module flappy_game #(
    parameter int GAP    = 100,
    parameter int SPEED  = 2,
    parameter int FLAP_V = 7,
    parameter int VMAX   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vneg,
    input  logic       flap,
    output logic [9:0] upx1,
    output logic [9:0] upy1,
    output logic [9:0] upx2,
    output logic [9:0] upy2,
    output logic [9:0] dnx1,
    output logic [9:0] dny1,
    output logic [9:0] dnx2,
    output logic [9:0] dny2,
    output logic [9:0] birdy,
    output logic [7:0] score,
    output logic [1:0] state,
    output logic       game_over
);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DYING = 2'd2, OVER = 2'd3} state_t;

    localparam logic [9:0] X_START  = 10'd604;
    localparam logic [9:0] X_WRAP   = 10'd268;
    localparam logic [9:0] X_SPAWN2 = 10'd436;
    localparam logic [9:0] X_SCORE  = 10'd392;
    localparam logic [9:0] Y_SKY    = 10'd85;
    localparam logic [9:0] Y_FLOOR  = 10'd391;
    localparam logic [9:0] Y_START  = 10'd240;
    localparam logic [9:0] DN_OFS   = 10'(150 + GAP);
    localparam logic [9:0] STEP     = 10'(SPEED);
    localparam logic signed [4:0] V_FLAP = 5'(-FLAP_V);
    localparam logic signed [4:0] V_MAX  = 5'(VMAX);

    logic              sync1_q, sync2_q, sync3_q;
    logic              pend_q, pend_d, flap_rise;
    logic [15:0]       lfsr_q;
    logic [9:0]        gap_up, gap_dn;
    state_t            state_q, state_d;
    logic [9:0]        birdy_q, birdy_d;
    logic signed [4:0] vel_q, vel_d;
    logic [7:0]        score_q, score_d;
    logic [9:0]        px_q [2], px_d [2];
    logic [9:0]        uy_q [2], uy_d [2];
    logic [9:0]        dy_q [2], dy_d [2];
    logic [1:0]        act_q, act_d;
    logic              hit;

    function automatic logic [9:0] move_bird(input logic [9:0] y, input logic signed [4:0] v);
        logic signed [11:0] sum;
        sum = $signed({2'b00, y}) + $signed({{7{v[4]}}, v});
        if (sum < $signed({2'b00, Y_SKY}))        move_bird = Y_SKY;
        else if (sum > $signed({2'b00, Y_FLOOR})) move_bird = Y_FLOOR;
        else                                      move_bird = sum[9:0];
    endfunction

    function automatic logic signed [4:0] gravity(input logic signed [4:0] v);
        gravity = (v >= V_MAX) ? V_MAX : v + 5'sd1;
    endfunction

`ifndef FLAPPY_NOCOLLIDE_EN
    // 11-bit arithmetic so x+51 and the gap bounds cannot wrap.
    function automatic logic pipe_hits(input logic [9:0] x, input logic [9:0] uy,
                                       input logic [9:0] dy, input logic [9:0] by);
        logic [10:0] xw, uyw, dyw, byw;
        xw  = {1'b0, x};
        uyw = {1'b0, uy};
        dyw = {1'b0, dy};
        byw = {1'b0, by};
        pipe_hits = (xw <= 11'd478) && (xw + 11'd51 >= 11'd445) &&
                    ((byw <= uyw + 11'd149) || (byw + 11'd23 >= dyw));
    endfunction
`endif

    assign flap_rise = sync2_q & ~sync3_q;
    // An edge seen on the tick cycle survives the tick and applies to the next one.
    assign pend_d    = vneg ? flap_rise : (pend_q | flap_rise);
    assign gap_up    = Y_SKY + {4'b0000, lfsr_q[5:0]} + {6'b000000, lfsr_q[3:0]};
    assign gap_dn    = gap_up + DN_OFS;

    always_comb begin
        state_d = state_q;
        birdy_d = birdy_q;
        vel_d   = vel_q;
        score_d = score_q;
        act_d   = act_q;
        px_d    = px_q;
        uy_d    = uy_q;
        dy_d    = dy_q;
        hit     = 1'b0;
        if (vneg) begin
            unique case (state_q)
                IDLE: if (pend_q) begin
                    state_d  = PLAY;
                    act_d[0] = 1'b1;
                    px_d[0]  = X_START;
                    uy_d[0]  = gap_up;
                    dy_d[0]  = gap_dn;
                    vel_d    = V_FLAP;
                    birdy_d  = move_bird(birdy_q, V_FLAP);
                end
                PLAY: begin
                    vel_d   = pend_q ? V_FLAP : gravity(vel_q);
                    birdy_d = move_bird(birdy_q, vel_d);
                    for (int i = 0; i < 2; i++) begin
                        if (act_q[i]) begin
                            if (px_q[i] == X_WRAP) begin
                                px_d[i] = X_START;
                                uy_d[i] = gap_up;
                                dy_d[i] = gap_dn;
                            end else begin
                                px_d[i] = px_q[i] - STEP;
                            end
                        end
                    end
                    if (px_d[0] == X_SPAWN2 && !act_q[1]) begin
                        act_d[1] = 1'b1;
                        px_d[1]  = X_START;
                        uy_d[1]  = gap_up;
                        dy_d[1]  = gap_dn;
                    end
                    for (int i = 0; i < 2; i++) begin
                        if (act_d[i] && px_d[i] == X_SCORE && score_d != 8'hFF)
                            score_d = score_d + 8'd1;
                    end
`ifndef FLAPPY_NOCOLLIDE_EN
                    for (int i = 0; i < 2; i++) begin
                        if (act_d[i] && pipe_hits(px_d[i], uy_d[i], dy_d[i], birdy_d))
                            hit = 1'b1;
                    end
`endif
                    if (birdy_d == Y_FLOOR) state_d = OVER;
                    else if (hit)           state_d = DYING;
                end
                DYING: begin
                    vel_d   = gravity(vel_q);
                    birdy_d = move_bird(birdy_q, vel_d);
                    if (birdy_d == Y_FLOOR) state_d = OVER;
                end
                OVER: if (pend_q) begin
                    state_d = IDLE;
                    birdy_d = Y_START;
                    vel_d   = '0;
                    score_d = '0;
                    act_d   = '0;
                    for (int i = 0; i < 2; i++) begin
                        px_d[i] = '0;
                        uy_d[i] = '0;
                        dy_d[i] = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            pend_q  <= 1'b0;
            lfsr_q  <= 16'hACE1;
            state_q <= IDLE;
            birdy_q <= Y_START;
            vel_q   <= '0;
            score_q <= '0;
            act_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                px_q[i] <= '0;
                uy_q[i] <= '0;
                dy_q[i] <= '0;
            end
        end else begin
            sync1_q <= flap;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            pend_q  <= pend_d;
            lfsr_q  <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            state_q <= state_d;
            birdy_q <= birdy_d;
            vel_q   <= vel_d;
            score_q <= score_d;
            act_q   <= act_d;
            for (int i = 0; i < 2; i++) begin
                px_q[i] <= px_d[i];
                uy_q[i] <= uy_d[i];
                dy_q[i] <= dy_d[i];
            end
        end
    end

    assign upx1      = px_q[0];
    assign upy1      = uy_q[0];
    assign dnx1      = px_q[0];
    assign dny1      = dy_q[0];
    assign upx2      = px_q[1];
    assign upy2      = uy_q[1];
    assign dnx2      = px_q[1];
    assign dny2      = dy_q[1];
    assign birdy     = birdy_q;
    assign score     = score_q;
    assign state     = state_q;
    assign game_over = (state_q == OVER);
endmodule

// File: doc/flappy_game.md
# flappy_game

Frame-rate game engine that produces every sprite position consumed by the `vga` renderer: bird vertical position and two scrolling pipe pairs (up/down). Game state advances exactly once per video frame, on the `vneg` pulse emitted by `vga`, so all position updates land inside vertical blanking. It also owns flap-button edge detection, pseudo-random gap placement, collision detection and scoring.

## Interface
Parameters:
- `GAP`, 100: vertical gap in rows between up-pipe bottom and down-pipe top.
- `SPEED`, 2: pipe scroll step in pixels per frame; must be even.
- `FLAP_V`, 7: upward velocity magnitude set by a flap.
- `VMAX`, 7: maximum downward velocity.

Ports:
- `clk`  in  1  pixel clock, same clock as `vga`.
- `rst`  in  1  synchronous, active-high reset.
- `vneg`  in  1  one-cycle frame tick from `vga`.
- `flap`  in  1  raw button level, asynchronous.
- `upx1`, `upy1`, `upx2`, `upy2`  out  10 each  up-pipe top-left corners, pipes 1 and 2.
- `dnx1`, `dny1`, `dnx2`, `dny2`  out  10 each  down-pipe top-left corners, pipes 1 and 2.
- `birdy`  out  10  bird top row; bird column fixed at 445.
- `score`  out  8  pipes passed, saturating at 255.
- `state`  out  2  IDLE=0, PLAY=1, DYING=2, OVER=3.
- `game_over`  out  1  high in OVER.

## Operation
- Geometry in screen coordinates: sky rows 85..414, ground starts at row 415. Bird box is 34×24, at columns 445..478 and rows birdy..birdy+23. Pipe box is 52×150.
- `flap` passes through a 2-flop synchronizer, then a rising-edge detect. Each edge sets a `flap_pend` flag, which is cleared on the next tick.
- LFSR: 16-bit, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1. It advances every clock.
- Gap draw: upy = 85 + lfsr[5:0] + lfsr[3:0], giving range 85..163. dny = upy + 150 + `GAP`. Set dnx equal to upx.
- Parked pipe: x=0 and y=0. The `vga` block blanks this position.
- Reset and IDLE values: birdy=240, vel=0, score=0, both pipes parked, inactive.
- IDLE: on a tick with `flap_pend`, enter PLAY. Pipe 1 becomes active at x=604 with a new gap. Velocity is set to −FLAP_V.
- PLAY, per tick, in this order:
  - vel ← −FLAP_V if `flap_pend`, else min(vel+1, VMAX). vel is 5-bit signed.
  - birdy ← birdy+vel, clamped to a minimum of 85 and a maximum of 391.
  - Each active pipe: if x==268, then x←604 and a new gap is drawn; otherwise x←x−SPEED.
  - When pipe 1 reaches x==436 and pipe 2 is inactive, activate pipe 2 at x=604 with a new gap.
  - Score increments, saturating, for each pipe whose new x==392.
  - Collision is checked on the new positions. A pipe hits when x≤478, x+51≥445, and either birdy≤upy+149 or birdy+23≥dny.
  - If birdy==391, go to OVER. Otherwise, if any pipe hits, go to DYING.
- DYING: pipes frozen, flaps ignored, gravity continues. When birdy reaches 391, go to OVER.
- OVER: everything frozen. On a tick with `flap_pend`, go to IDLE and restore the reset values, except the LFSR, which keeps running.
- Width rule: comparisons use 11-bit sums so that x+51 cannot wrap.

## Timing
- All outputs are registered. They update on the clock edge where `vneg`=1 is sampled, and are stable for the rest of the frame.
- A flap edge reaches `flap_pend` 3 cycles after the raw rise (2-flop synchronizer plus edge register).
- An edge that becomes pending in the same cycle as `vneg` applies to the next tick.
- Pipe period: 169 frames. Pipe 2 lags pipe 1 by 84 frames.
- `rst` high on any edge forces IDLE values on the next edge, including mid-PLAY. It has priority over `vneg`.
- Ground contact and pipe hit on the same tick resolve to OVER.

## Configuration
- `FLAPPY_NOCOLLIDE_EN` defined: pipe collision is compiled out. DYING is unreachable and only ground contact ends the game. Used for demos and visual bring-up.
- Undefined: full collision as specified in Operation.

## Test plan
- Reset, then 5 ticks with no flap: birdy=240, upx1=0, state=0, score=0 throughout.
- Flap, then first tick: state=1, upx1=604, vel=−7, birdy=233. Next tick without flap: birdy=227, upx1=602.
- No further flaps: vel saturates at 7, birdy clamps at 391, state=3, `game_over`=1, pipes frozen.
- Force birdy into the gap by repeated flaps: upx1 hits 392, score=1. At upx1=436, pipe 2 appears at 604. After upx1=268, the next tick gives upx1=604 with a new upy1 in 85..163 and dny1=upy1+250.
- Bird overlapping the up-pipe at x=478: state=2, pipes frozen, bird falls to 391, then state=3. With `FLAPPY_NOCOLLIDE_EN` defined, state stays 1.
- `rst` asserted mid-PLAY coincident with `vneg`: all outputs equal IDLE values one edge later. Flap in OVER: state=0.
